// File: rtl/usb_rx_stp_unstuff_if.sv
// usb_rx_stp_unstuff_if
//   Bundles the bit-level receive inputs and the byte-level outputs of the
//   USB full-speed receive deserializer.
//   Ports (signals):
//     rx_active, bit_strobe, d_bit : from line decoder to deserializer
//     rx_data[7:0], byte_valid     : completed byte and its one-cycle pulse
//     stuff_err, align_err         : sticky per-packet error flags
//     byte_cnt[CNT_BITS-1:0]       : saturating per-packet byte count
//   Modports:
//     slave  : the deserializer (consumes bits, produces bytes)
//     master : the driver/observer side (line decoder + packet decoder)
interface usb_rx_stp_unstuff_if #(
  parameter int CNT_BITS = 7
);
  logic                rx_active;
  logic                bit_strobe;
  logic                d_bit;
  logic [7:0]          rx_data;
  logic                byte_valid;
  logic                stuff_err;
  logic                align_err;
  logic [CNT_BITS-1:0] byte_cnt;

  modport slave (
    input  rx_active, bit_strobe, d_bit,
    output rx_data, byte_valid, stuff_err, align_err, byte_cnt
  );

  modport master (
    output rx_active, bit_strobe, d_bit,
    input  rx_data, byte_valid, stuff_err, align_err, byte_cnt
  );
endinterface

// File: rtl/usb_rx_stp_unstuff.sv
// usb_rx_stp_unstuff
//   Receive-side serial-to-parallel deserializer for USB full speed.
//   Takes NRZI-decoded bits on bit_strobe, drops stuffed zeros after
//   MAX_ONES consecutive ones, flags a stuffed one as stuff_err, builds
//   bytes LSB-first and pulses byte_valid with each completed byte.
//   Ports:
//     clk  : system clock, rising edge
//     rst  : asynchronous active-high reset
//     bus  : usb_rx_stp_unstuff_if.slave (see interface header)
module usb_rx_stp_unstuff #(
  parameter int MAX_ONES = 6,
  parameter int CNT_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  usb_rx_stp_unstuff_if.slave   bus
);

  localparam int ONES_W = $clog2(MAX_ONES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t              state_q,      state_d;
  logic [7:0]          sr_q,         sr_d;
  logic [2:0]          bit_cnt_q,    bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt_q,   ones_cnt_d;
  logic [7:0]          rx_data_q,    rx_data_d;
  logic                byte_valid_q, byte_valid_d;
  logic                stuff_err_q,  stuff_err_d;
  logic                align_err_q,  align_err_d;
  logic [CNT_BITS-1:0] byte_cnt_q,   byte_cnt_d;

  logic [7:0]          shifted;

  assign shifted = {bus.d_bit, sr_q[7:1]};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    rx_data_d    = rx_data_q;
    byte_valid_d = 1'b0;
    stuff_err_d  = stuff_err_q;
    align_err_d  = align_err_q;
    byte_cnt_d   = byte_cnt_q;

    case (state_q)
      S_IDLE: begin
        // Packet start: the strobe in this cycle is deliberately ignored.
        if (bus.rx_active) begin
          state_d     = S_RECV;
          sr_d        = 8'h00;
          bit_cnt_d   = 3'd0;
          ones_cnt_d  = '0;
          byte_cnt_d  = '0;
          stuff_err_d = 1'b0;
          align_err_d = 1'b0;
        end
      end

      S_RECV: begin
        if (!bus.rx_active) begin
          state_d = S_IDLE;
          if (bit_cnt_q != 3'd0) align_err_d = 1'b1;
        end else if (bus.bit_strobe) begin
          if (ones_cnt_q == ONES_W'(MAX_ONES)) begin
            // Stuff bit position: a zero is dropped, a one is a protocol error.
            if (bus.d_bit) begin
              stuff_err_d = 1'b1;
              state_d     = S_ERROR;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            sr_d       = shifted;
            ones_cnt_d = bus.d_bit ? ones_cnt_q + ONES_W'(1) : '0;
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d    = shifted;
              byte_valid_d = 1'b1;
              if (byte_cnt_q != '1) byte_cnt_d = byte_cnt_q + CNT_BITS'(1);
            end
          end
        end
      end

      S_ERROR: begin
        // Swallow the rest of the packet; align_err is not evaluated here.
        if (!bus.rx_active) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sr_q         <= 8'h00;
      bit_cnt_q    <= 3'd0;
      ones_cnt_q   <= '0;
      rx_data_q    <= 8'h00;
      byte_valid_q <= 1'b0;
      stuff_err_q  <= 1'b0;
      align_err_q  <= 1'b0;
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      rx_data_q    <= rx_data_d;
      byte_valid_q <= byte_valid_d;
      stuff_err_q  <= stuff_err_d;
      align_err_q  <= align_err_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

  assign bus.rx_data    = rx_data_q;
  assign bus.byte_valid = byte_valid_q;
  assign bus.stuff_err  = stuff_err_q;
  assign bus.align_err  = align_err_q;
  assign bus.byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_usb_rx_stp_unstuff.sv
// tb_usb_rx_stp_unstuff
//   Scoreboard bench for usb_rx_stp_unstuff: every data bit driven also
//   feeds a small byte-assembly model that pushes the expected byte and
//   byte count; a monitor pops and compares on each byte_valid.
module tb_usb_rx_stp_unstuff;

  localparam int CNT_BITS = 7;
  localparam int MAX_ONES = 6;

  logic clk;
  logic rst;

  usb_rx_stp_unstuff_if #(.CNT_BITS(CNT_BITS)) bus ();

  usb_rx_stp_unstuff #(
    .MAX_ONES(MAX_ONES),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard and reference model state
  logic [7:0]          q_data[$];
  logic [CNT_BITS-1:0] q_cnt[$];
  logic [7:0]          m_sr;
  int                  m_bits;
  int                  m_ones;
  logic [CNT_BITS-1:0] m_cnt;
  logic [7:0]          m_last;
  int                  n_valid;

  task automatic model_clear();
    m_sr   = 8'h00;
    m_bits = 0;
    m_ones = 0;
    m_cnt  = '0;
  endtask

  task automatic model_bit(input logic b);
    m_sr = {b, m_sr[7:1]};
    m_bits++;
    if (m_bits == 8) begin
      if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
      q_data.push_back(m_sr);
      q_cnt.push_back(m_cnt);
      m_last = m_sr;
      m_bits = 0;
    end
  endtask

  // Raw strobe: called and returns at a falling edge; 2-cycle spacing.
  task automatic send_bit(input logic b);
    bus.bit_strobe = 1'b1;
    bus.d_bit      = b;
    @(negedge clk);
    bus.bit_strobe = 1'b0;
    bus.d_bit      = 1'b0;
    @(negedge clk);
  endtask

  // Data bit with automatic stuff insertion after MAX_ONES ones.
  task automatic send_data_bit(input logic b);
    model_bit(b);
    send_bit(b);
    m_ones = b ? m_ones + 1 : 0;
    if (m_ones == MAX_ONES) begin
      send_bit(1'b0);
      m_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic start_pkt();
    bus.rx_active = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic end_pkt();
    bus.rx_active = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst && bus.byte_valid === 1'b1) begin
      n_valid++;
      if (q_data.size() == 0) begin
        check_val("unexpected_byte_valid", 32'd1, 32'd0);
      end else begin
        check_val("rx_data", {24'h0, bus.rx_data}, {24'h0, q_data.pop_front()});
        check_val("byte_cnt_at_valid", {25'h0, bus.byte_cnt}, {25'h0, q_cnt.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int vbase;
    n_valid        = 0;
    m_last         = 8'h00;
    model_clear();
    rst            = 1'b1;
    bus.rx_active  = 1'b0;
    bus.bit_strobe = 1'b0;
    bus.d_bit      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_rx_data",    {24'h0, bus.rx_data}, 32'h00);
    check_val("rst_byte_valid", {31'h0, bus.byte_valid}, 32'h0);
    check_val("rst_stuff_err",  {31'h0, bus.stuff_err}, 32'h0);
    check_val("rst_align_err",  {31'h0, bus.align_err}, 32'h0);
    check_val("rst_byte_cnt",   {25'h0, bus.byte_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Strobes while idle do nothing
    send_bit(1'b1);
    send_bit(1'b0);
    check_val("idle_strobe_cnt", {25'h0, bus.byte_cnt}, 32'h0);

    // Single byte 0xA5
    start_pkt();
    send_byte(8'hA5);
    end_pkt();
    check_val("a5_stuff_err", {31'h0, bus.stuff_err}, 32'h0);
    check_val("a5_align_err", {31'h0, bus.align_err}, 32'h0);
    check_val("a5_byte_cnt",  {25'h0, bus.byte_cnt}, 32'd1);
    check_val("a5_rx_data",   {24'h0, bus.rx_data}, 32'hA5);

    // Stuffing inside a byte (0xFF) and right at a byte boundary (0xFC)
    start_pkt();
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'hFC);
    send_byte(8'h00);
    end_pkt();
    check_val("stuff_stuff_err", {31'h0, bus.stuff_err}, 32'h0);
    check_val("stuff_align_err", {31'h0, bus.align_err}, 32'h0);
    check_val("stuff_byte_cnt",  {25'h0, bus.byte_cnt}, 32'd4);

    // Stuff error
    start_pkt();
    vbase = n_valid;
    for (int i = 0; i < MAX_ONES; i++) send_bit(1'b1);
    check_val("pre_stuff_err", {31'h0, bus.stuff_err}, 32'h0);
    send_bit(1'b1);
    check_val("stuff_err_set", {31'h0, bus.stuff_err}, 32'h1);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    check_val("err_no_valid", n_valid - vbase, 32'd0);
    end_pkt();
    check_val("err_sticky",    {31'h0, bus.stuff_err}, 32'h1);
    check_val("err_no_align",  {31'h0, bus.align_err}, 32'h0);
    start_pkt();
    check_val("err_cleared",   {31'h0, bus.stuff_err}, 32'h0);
    check_val("err_cnt_clear", {25'h0, bus.byte_cnt}, 32'h0);
    end_pkt();

    // Misaligned end
    start_pkt();
    vbase = n_valid;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.rx_active = 1'b0;
    @(negedge clk);
    check_val("align_err_set", {31'h0, bus.align_err}, 32'h1);
    @(negedge clk);
    check_val("align_no_valid", n_valid - vbase, 32'd0);
    check_val("align_rx_hold",  {24'h0, bus.rx_data}, {24'h0, m_last});
    start_pkt();
    check_val("align_cleared",  {31'h0, bus.align_err}, 32'h0);
    end_pkt();

    // Asynchronous reset mid-byte
    start_pkt();
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_rx_data",  {24'h0, bus.rx_data}, 32'h00);
    check_val("arst_byte_cnt", {25'h0, bus.byte_cnt}, 32'h0);
    check_val("arst_valid",    {31'h0, bus.byte_valid}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    send_byte(8'h3C);
    end_pkt();
    check_val("arst_3c_data", {24'h0, bus.rx_data}, 32'h3C);
    check_val("arst_3c_cnt",  {25'h0, bus.byte_cnt}, 32'd1);

    // Counter saturation
    start_pkt();
    vbase = n_valid;
    for (int i = 0; i < 130; i++) send_byte(8'h00);
    end_pkt();
    check_val("sat_valids",   n_valid - vbase, 32'd130);
    check_val("sat_byte_cnt", {25'h0, bus.byte_cnt}, 32'd127);

    check_val("queue_drained", q_data.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
